uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
Parametrised next-generation UART transmit path: write-side FIFO, programmable baud divider, 5..DATA_W data bits, parity and stop-bit modes, break generation and CTS flow control.
Sits between the UART register block (push side) and the pad/loopback logic (txd side) in the next uart_top revision.
Replaces the fixed 8-bit single-holding-register transmitter.

Parameters:
DATA_W, 8, maximum data bits per frame; legal 5..9.
FIFO_DEPTH, 16, TX FIFO entries; power of two, >=2.
DIV_W, 16, baud divisor width.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable_i  in  1  transmitter enable; low = flush and idle
div_i  in  DIV_W  bit period = div_i+1 clk cycles
dbits_i  in  4  data bits per frame; values clamped to 5..DATA_W
par_i  in  2  parity mode: 00 none, 01 even, 10 odd, 11 none
stop2_i  in  1  1 = two stop bits, 0 = one stop bit
txbrk_i  in  1  break request
cts_i  in  1  clear-to-send, active high
wr_valid_i  in  1  push request
wr_data_i  in  DATA_W  push data, LSB transmitted first
wr_ready_o  out  1  FIFO not full
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
busy_o  out  1  frame in progress (FSM not IDLE)
tx_empty_o  out  1  FIFO empty and FSM IDLE
txd_o  out  1  serial output, idle high

Behaviour:
- Reset values: txd_o=1, wr_ready_o=1, fifo_level_o=0, busy_o=0, tx_empty_o=1; FSM=IDLE; all pointers and counters cleared.
- Push: accepted when wr_valid_i & wr_ready_o & enable_i. Level visible the next cycle.
  - When full, writes are refused even if a pop happens in the same cycle.
  - Simultaneous push and pop on a non-empty FIFO leaves the level unchanged.
- Pop: in IDLE when FIFO not empty & cts_i & !txbrk_i & enable_i.
  - Pop cycle latches data, dbits (clamped), par_i and stop2_i into the frame registers. Config changes mid-frame have no effect.
  - FSM enters START; txd_o falls the cycle after the pop.
  - Push-to-txd-fall latency from an empty, idle engine: 2 cycles.
- FSM: IDLE -> START -> DATA -> (PARITY if par_i is 01/10) -> STOP -> IDLE, or STOP2 when two stop bits are latched.
  - Every state lasts exactly div_i+1 cycles (baud counter reloads on each state entry; div_i=0 gives 1 cycle per bit).
  - div_i is sampled on every reload.
  - DATA shifts LSB first; bit counter runs 0..dbits-1. Bits above dbits are not sent.
- Parity covers the transmitted data bits only. Even: parity bit = XOR of the data bits. Odd: its inverse.
- Frame levels: START=0, STOP/STOP2=1.
- Back-to-back frames: STOP exits directly into START when the pop condition holds at STOP end, so there is no idle gap.
- CTS: checked only at frame boundaries; deassertion mid-frame never truncates a frame.
- Break: while txbrk_i=1 and FSM is IDLE, txd_o=0 and no pops occur. A request during a frame takes effect after STOP/STOP2 completes.
- enable_i low:
  - FSM forced to IDLE the next cycle; txd_o=1.
  - FIFO flushed (level 0); pushes ignored.
  - A frame in progress is aborted.
- Reset mid-frame: txd_o returns high immediately (asynchronous), FIFO empty.

Optional Feature:
UART_TX_TRIG_EN: adds input trig_lvl_i [$clog2(FIFO_DEPTH):0] and output tx_trig_o.
- tx_trig_o is a 1-cycle pulse when fifo_level_o transitions from >trig_lvl_i to <=trig_lvl_i. Reset value 0.
- No pulse on a flush caused by enable_i.
- Without the macro, neither port exists and no threshold logic is built.

Test Plan:
- div_i=3, dbits=8, par=00, stop2=0, push 0xA5 -> txd: 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; busy_o for 40 cycles; tx_empty_o returns 1.
- dbits=7, par=01, push 0x55 (bit7 ignored) -> 7 data bits 1,0,1,0,1,0,1 then parity 0 (even); par=10 -> parity 1.
- Push 17 words into depth 16 with cts_i=0 -> wr_ready_o=0 after 16, level=16, 17th dropped. Raise cts_i -> 16 frames back-to-back with no idle cycle between STOP and START.
- Drop cts_i mid-frame -> current frame completes, txd_o stays 1 afterward, level unchanged until cts_i=1.
- Assert txbrk_i during DATA -> frame completes, then txd_o=0 until release. Release -> next queued frame starts after 1 idle cycle minimum.
- Deassert enable_i mid-DATA with level=5 -> next cycle txd_o=1, busy_o=0, level=0, and tx_trig_o not pulsed (macro on, trig_lvl_i=2).

Source files
------------

// File: rtl/uart_tx_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_engine
// Purpose  : UART transmit path. TX FIFO, programmable baud divider,
//            5..DATA_W data bits, parity, 1/2 stop bits, break and CTS.
//            Optional FIFO threshold pulse enabled by macro UART_TX_TRIG_EN.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_engine #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable_i,
   input  logic [DIV_W-1:0]              div_i,
   input  logic [3:0]                    dbits_i,
   input  logic [1:0]                    par_i,
   input  logic                          stop2_i,
   input  logic                          txbrk_i,
   input  logic                          cts_i,
   input  logic                          wr_valid_i,
   input  logic [DATA_W-1:0]             wr_data_i,
   output logic                          wr_ready_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          busy_o,
   output logic                          tx_empty_o,
`ifdef UART_TX_TRIG_EN
   input  logic [$clog2(FIFO_DEPTH):0]   trig_lvl_i,
   output logic                          tx_trig_o,
`endif
   output logic                          txd_o
);

   localparam int         AW       = $clog2(FIFO_DEPTH);
   localparam int         LW       = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
   localparam logic [3:0] MINBITS  = 4'd5;
   localparam logic [3:0] MAXBITS  = 4'(DATA_W);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_STOP2  = 3'd5;

   // ------------------------------------------------------------------------
   // TX FIFO
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wptr_q, rptr_q;
   logic [LW-1:0]     level_q, level_d;
   logic              push, pop;
   logic              fifo_ne;
   logic [DATA_W-1:0] head_data;

   assign wr_ready_o   = (level_q != FULL_LVL);
   assign push         = wr_valid_i & wr_ready_o & enable_i;
   assign fifo_ne      = (level_q != '0);
   assign head_data    = mem_q[rptr_q];
   assign fifo_level_o = level_q;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= wr_data_i;
      end
   end

   always_comb begin
      level_d = level_q;
      if (!enable_i) begin
         level_d = '0;
      end else if (push && !pop) begin
         level_d = level_q + LW'(1);
      end else if (pop && !push) begin
         level_d = level_q - LW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else if (!enable_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (push) begin
            wptr_q <= wptr_q + AW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + AW'(1);
         end
         level_q <= level_d;
      end
   end

   // ------------------------------------------------------------------------
   // Frame configuration captured at pop time
   // ------------------------------------------------------------------------
   logic [3:0] nbits_clamp;
   logic       head_par;

   always_comb begin
      nbits_clamp = dbits_i;
      if (dbits_i < MINBITS) begin
         nbits_clamp = MINBITS;
      end else if (dbits_i > MAXBITS) begin
         nbits_clamp = MAXBITS;
      end
   end

   // Parity covers only the bits that will actually be shifted out
   always_comb begin
      head_par = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
         if (i < int'(nbits_clamp)) begin
            head_par = head_par ^ head_data[i];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Transmit FSM
   // ------------------------------------------------------------------------
   logic [2:0]        state_q, state_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        bit_q, bit_d;
   logic [3:0]        nbits_q, nbits_d;
   logic [DATA_W-1:0] shr_q, shr_d;
   logic              parbit_q, parbit_d;
   logic              paren_q, paren_d;
   logic              stop2_q, stop2_d;
   logic              brk_q;
   logic              txd_q, txd_d;
   logic              pop_ok, bit_end, start;

   // brk_q holds off the first pop after a break so the line marks high first
   assign pop_ok  = fifo_ne & cts_i & ~txbrk_i & ~brk_q & enable_i;
   assign bit_end = (cnt_q == '0);
   assign pop     = start;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shr_d    = shr_q;
      nbits_d  = nbits_q;
      parbit_d = parbit_q;
      paren_d  = paren_q;
      stop2_d  = stop2_q;
      start    = 1'b0;
      if (!enable_i) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         bit_d   = '0;
      end else if (state_q == S_IDLE) begin
         start = pop_ok;
      end else if (!bit_end) begin
         cnt_d = cnt_q - DIV_W'(1);
      end else begin
         cnt_d = div_i;
         case (state_q)
            S_START: begin
               state_d = S_DATA;
               bit_d   = '0;
            end
            S_DATA: begin
               if (bit_q == nbits_q - 4'd1) begin
                  state_d = paren_q ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + 4'd1;
                  shr_d = {1'b0, shr_q[DATA_W-1:1]};
               end
            end
            S_PARITY: state_d = S_STOP;
            S_STOP: begin
               if (stop2_q) begin
                  state_d = S_STOP2;
               end else begin
                  state_d = S_IDLE;
                  start   = pop_ok;
               end
            end
            S_STOP2: begin
               state_d = S_IDLE;
               start   = pop_ok;
            end
            default: state_d = S_IDLE;
         endcase
      end
      if (start) begin
         state_d  = S_START;
         cnt_d    = div_i;
         bit_d    = '0;
         shr_d    = head_data;
         nbits_d  = nbits_clamp;
         parbit_d = head_par ^ par_i[1];
         paren_d  = par_i[1] ^ par_i[0];
         stop2_d  = stop2_i;
      end
   end

   // Line level is registered from the next state so txd_o never glitches
   always_comb begin
      case (state_d)
         S_IDLE:   txd_d = ~(txbrk_i & enable_i);
         S_START:  txd_d = 1'b0;
         S_DATA:   txd_d = shr_d[0];
         S_PARITY: txd_d = parbit_q;
         default:  txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         nbits_q  <= MINBITS;
         shr_q    <= '0;
         parbit_q <= 1'b0;
         paren_q  <= 1'b0;
         stop2_q  <= 1'b0;
         brk_q    <= 1'b0;
         txd_q    <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         nbits_q  <= nbits_d;
         shr_q    <= shr_d;
         parbit_q <= parbit_d;
         paren_q  <= paren_d;
         stop2_q  <= stop2_d;
         brk_q    <= txbrk_i;
         txd_q    <= txd_d;
      end
   end

   assign txd_o      = txd_q;
   assign busy_o     = (state_q != S_IDLE);
   assign tx_empty_o = ~fifo_ne & (state_q == S_IDLE);

   // ------------------------------------------------------------------------
   // FIFO threshold pulse
   // ------------------------------------------------------------------------
`ifdef UART_TX_TRIG_EN
   logic trig_q;

   // Gated by enable_i so a flush never reads as a drain through the threshold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_q <= 1'b0;
      end else begin
         trig_q <= enable_i && (level_q > trig_lvl_i) && (level_d <= trig_lvl_i);
      end
   end

   assign tx_trig_o = trig_q;
`else
   // No threshold logic in this build
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for uart_tx_engine: directed + randomized frames checked against a
// frame-level reference model (bit list built from the data and config).
module tb_uart_tx_engine;
   localparam int DATA_W     = 8;
   localparam int FIFO_DEPTH = 16;
   localparam int DIV_W      = 16;
   localparam int LW         = $clog2(FIFO_DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              enable = 1'b1;
   logic [DIV_W-1:0]  div = 16'd3;
   logic [3:0]        dbits = 4'd8;
   logic [1:0]        par = 2'b00;
   logic              stop2 = 1'b0;
   logic              txbrk = 1'b0;
   logic              cts = 1'b1;
   logic              wr_valid = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              wr_ready_o;
   logic [LW-1:0]     fifo_level_o;
   logic              busy_o;
   logic              tx_empty_o;
   logic              txd_o;
`ifdef UART_TX_TRIG_EN
   logic [LW-1:0]     trig_lvl = LW'(2);
   logic              tx_trig_o;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int busy_cnt = 0;
   int trig_cnt = 0;

   uart_tx_engine #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable_i     (enable),
      .div_i        (div),
      .dbits_i      (dbits),
      .par_i        (par),
      .stop2_i      (stop2),
      .txbrk_i      (txbrk),
      .cts_i        (cts),
      .wr_valid_i   (wr_valid),
      .wr_data_i    (wr_data),
      .wr_ready_o   (wr_ready_o),
      .fifo_level_o (fifo_level_o),
      .busy_o       (busy_o),
      .tx_empty_o   (tx_empty_o),
`ifdef UART_TX_TRIG_EN
      .trig_lvl_i   (trig_lvl),
      .tx_trig_o    (tx_trig_o),
`endif
      .txd_o        (txd_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (busy_o) busy_cnt++;
`ifdef UART_TX_TRIG_EN
      if (tx_trig_o) trig_cnt++;
`endif
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (time %0t, limit 2000000)", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference frame: start, clamped data bits LSB first, optional parity, stops
   function automatic void model_frame(input logic [7:0] d, input int db, input logic [1:0] pm,
                                       input logic s2, output logic [15:0] bits, output int nb);
      int n;
      int ones;
      n    = (db < 5) ? 5 : ((db > DATA_W) ? DATA_W : db);
      bits = '0;
      nb   = 1;
      ones = 0;
      for (int i = 0; i < n; i++) begin
         bits[nb] = d[i];
         ones += int'(d[i]);
         nb++;
      end
      if (pm == 2'b01) begin
         bits[nb] = ones[0];
         nb++;
      end else if (pm == 2'b10) begin
         bits[nb] = ~ones[0];
         nb++;
      end
      bits[nb] = 1'b1;
      nb++;
      if (s2) begin
         bits[nb] = 1'b1;
         nb++;
      end
   endfunction

   // Waits for a start bit, then samples every cycle of every bit period
   task automatic rx_frame(input string tag, input int dv, input logic [15:0] exp,
                           input int nb, output int gap);
      logic [15:0] obs;
      int          bad;
      gap = 0;
      obs = '0;
      bad = 0;
      @(negedge clk);
      while (txd_o !== 1'b0 && gap < 5000) begin
         gap++;
         @(negedge clk);
      end
      if (gap >= 5000) begin
         chk({tag, "_start_timeout"}, 32'(gap), 32'd0);
         return;
      end
      for (int b = 0; b < nb; b++) begin
         for (int c = 0; c <= dv; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (c == 0) obs[b] = txd_o;
            else if (txd_o !== obs[b]) bad++;
         end
      end
      chk({tag, "_bits"}, 32'(obs), 32'(exp));
      chk({tag, "_hold"}, 32'(bad), 32'd0);
   endtask

   task automatic push(input logic [7:0] d);
      wr_data  = d;
      wr_valid = 1'b1;
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] eb;
      int          nb, gap, b0, t0, cnt;
      logic [7:0]  q[$];
      logic [7:0]  d0, d1;

      // ---- reset state
      #20;
      chk("rst_txd", 32'(txd_o), 32'd1);
      chk("rst_wr_ready", 32'(wr_ready_o), 32'd1);
      chk("rst_level", 32'(fifo_level_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_tx_empty", 32'(tx_empty_o), 32'd1);
`ifdef UART_TX_TRIG_EN
      chk("rst_trig", 32'(tx_trig_o), 32'd0);
`endif
      #3 rst_n = 1'b1;
      tick(1);

      // ---- 0xA5, div 3, 8N1
      b0 = busy_cnt;
      push(8'hA5);
      model_frame(8'hA5, 8, 2'b00, 1'b0, eb, nb);
      rx_frame("a5", 3, eb, nb, gap);
      chk("a5_latency", 32'(gap + 1), 32'd2);
      @(negedge clk);
      chk("a5_busy_cycles", 32'(busy_cnt - b0), 32'd40);
      chk("a5_tx_empty", 32'(tx_empty_o), 32'd1);
      chk("a5_idle_txd", 32'(txd_o), 32'd1);

      // ---- 7 data bits, even then odd parity
      div   = 16'd1;
      dbits = 4'd7;
      for (int k = 0; k < 2; k++) begin
         par = (k == 0) ? 2'b01 : 2'b10;
         tick(1);
         push(8'h55);
         model_frame(8'h55, 7, par, 1'b0, eb, nb);
         rx_frame((k == 0) ? "par_even" : "par_odd", 1, eb, nb, gap);
      end

      // ---- randomized frames; config scrambled once the frame is latched
      for (int k = 0; k < 10; k++) begin
         int         dv;
         logic [3:0] db;
         logic [1:0] pr;
         logic       s2;
         dv    = int'($urandom_range(0, 3));
         db    = 4'($urandom_range(0, 15));
         pr    = 2'($urandom);
         s2    = 1'($urandom);
         d0    = 8'($urandom);
         div   = DIV_W'(dv);
         dbits = db;
         par   = pr;
         stop2 = s2;
         tick(1);
         push(d0);
         model_frame(d0, int'(db), pr, s2, eb, nb);
         fork
            rx_frame("rand", dv, eb, nb, gap);
            begin
               @(posedge clk);
               #1;
               dbits = ~db;
               par   = ~pr;
               stop2 = ~s2;
            end
         join
         chk("rand_latency", 32'(gap + 1), 32'd2);
      end

      // ---- simultaneous push and pop on a non-empty FIFO
      div = '0; dbits = 4'd8; par = 2'b00; stop2 = 1'b0; cts = 1'b0;
      tick(2);
      q.delete();
      for (int i = 0; i < 2; i++) begin
         d0 = 8'($urandom);
         q.push_back(d0);
         push(d0);
      end
      d0 = 8'($urandom);
      q.push_back(d0);
      wr_data = d0; wr_valid = 1'b1; cts = 1'b1;
      tick(1);
      wr_valid = 1'b0;
      chk("pushpop_level", 32'(fifo_level_o), 32'd2);
      for (int i = 0; i < 3; i++) begin
         model_frame(q.pop_front(), 8, 2'b00, 1'b0, eb, nb);
         rx_frame("pushpop", 0, eb, nb, gap);
         if (i > 0) chk("pushpop_gap", 32'(gap), 32'd0);
      end

      // ---- fill to 16 with CTS low; 17th push refused while a pop happens
      cts = 1'b0;
      tick(2);
      t0 = trig_cnt;
      q.delete();
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         d0 = 8'($urandom);
         q.push_back(d0);
         wr_data = d0;
         wr_valid = 1'b1;
         tick(1);
      end
      chk("full_wr_ready", 32'(wr_ready_o), 32'd0);
      chk("full_level", 32'(fifo_level_o), 32'd16);
      wr_data = 8'h3C;
      cts = 1'b1;
      tick(1);
      wr_valid = 1'b0;
      chk("full_pop_no_push_level", 32'(fifo_level_o), 32'd15);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         model_frame(q.pop_front(), 8, 2'b00, 1'b0, eb, nb);
         rx_frame("b2b", 0, eb, nb, gap);
         chk("b2b_gap", 32'(gap), 32'd0);
      end
      cnt = 0;
      repeat (15) begin
         @(negedge clk);
         if (txd_o !== 1'b1) cnt++;
      end
      chk("full_17th_dropped", 32'(cnt), 32'd0);
      chk("full_drained_empty", 32'(tx_empty_o), 32'd1);
`ifdef UART_TX_TRIG_EN
      chk("trig_drain_pulses", 32'(trig_cnt - t0), 32'd1);
`endif

      // ---- CTS dropped mid-frame
      div = 16'd1; cts = 1'b1;
      tick(1);
      d0 = 8'($urandom); d1 = 8'($urandom);
      push(d0);
      push(d1);
      model_frame(d0, 8, 2'b00, 1'b0, eb, nb);
      fork
         rx_frame("cts_f1", 1, eb, nb, gap);
         begin
            tick(6);
            cts = 1'b0;
         end
      join
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (txd_o !== 1'b1) cnt++;
      end
      chk("cts_line_low_cycles", 32'(cnt), 32'd0);
      chk("cts_level_held", 32'(fifo_level_o), 32'd1);
      chk("cts_busy", 32'(busy_o), 32'd0);
      @(posedge clk); #1;
      cts = 1'b1;
      model_frame(d1, 8, 2'b00, 1'b0, eb, nb);
      rx_frame("cts_f2", 1, eb, nb, gap);

      // ---- break requested during DATA
      tick(2);
      d0 = 8'($urandom); d1 = 8'($urandom);
      push(d0);
      push(d1);
      model_frame(d0, 8, 2'b00, 1'b0, eb, nb);
      fork
         rx_frame("brk_f1", 1, eb, nb, gap);
         begin
            tick(6);
            txbrk = 1'b1;
         end
      join
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (txd_o !== 1'b0) cnt++;
      end
      chk("brk_line_high_cycles", 32'(cnt), 32'd0);
      chk("brk_busy", 32'(busy_o), 32'd0);
      chk("brk_level_held", 32'(fifo_level_o), 32'd1);
      @(posedge clk); #1;
      txbrk = 1'b0;
      @(negedge clk);
      model_frame(d1, 8, 2'b00, 1'b0, eb, nb);
      rx_frame("brk_f2", 1, eb, nb, gap);
      chk("brk_release_idle", 32'(gap >= 1), 32'd1);

      // ---- enable dropped mid-DATA with five words queued
      div = 16'd2;
      tick(2);
      for (int i = 0; i < 6; i++) push(8'($urandom));
      tick(4);
      chk("en_level_before", 32'(fifo_level_o), 32'd5);
      chk("en_busy_before", 32'(busy_o), 32'd1);
      t0 = trig_cnt;
      enable = 1'b0;
      tick(1);
      chk("en_txd", 32'(txd_o), 32'd1);
      chk("en_busy", 32'(busy_o), 32'd0);
      chk("en_level", 32'(fifo_level_o), 32'd0);
      push(8'hFF);
      chk("en_push_ignored", 32'(fifo_level_o), 32'd0);
      tick(3);
      chk("en_txd_idle", 32'(txd_o), 32'd1);
`ifdef UART_TX_TRIG_EN
      chk("en_no_trig", 32'(trig_cnt - t0), 32'd0);
`endif
      enable = 1'b1;
      tick(1);
      d0 = 8'($urandom);
      push(d0);
      model_frame(d0, 8, 2'b00, 1'b0, eb, nb);
      rx_frame("en_after", 2, eb, nb, gap);
      chk("en_after_latency", 32'(gap + 1), 32'd2);

      // ---- asynchronous reset mid-frame
      tick(2);
      push(8'h00);
      push(8'h00);
      tick(4);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_txd", 32'(txd_o), 32'd1);
      chk("arst_busy", 32'(busy_o), 32'd0);
      chk("arst_level", 32'(fifo_level_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (txd_o !== 1'b1) cnt++;
      end
      chk("arst_line_quiet", 32'(cnt), 32'd0);
      chk("arst_tx_empty", 32'(tx_empty_o), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
